// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU address path (master) and the memory responder (slave).
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder over a byte-lane word RAM with fixed access latency.
// Optional error trapping (bad size, misalignment, out of range) is enabled by defining MEM_ERR_TRAP_EN.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int READ_LAT    = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_responder_if.slave bus
);
  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = 3'(READ_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t          r_state;
  logic [2:0]      r_cnt;
  logic            r_ready;
  logic            r_resp_valid;
  logic            r_err;
  logic            r_write;
  logic [3:0]      r_be;
  logic [31:0]     r_wdata;
  logic [AW-1:0]   r_idx;
  logic [1:0]      r_shift;
  logic [1:0]      r_size;

  logic            w_accept;
  logic            w_do_access;
  logic            w_err;
  logic [1:0]      w_size_n;
  logic [1:0]      w_lane_n;
  logic [3:0]      w_be;
  logic [31:0]     w_wrep;
  logic [31:0]     w_raw;
  logic [31:0]     w_shifted;
  logic [31:0]     w_mask;

  assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
  assign w_do_access = (r_state == S_BUSY) && (r_cnt == 3'd0);

`ifdef MEM_ERR_TRAP_EN
  always_comb begin
    w_size_n = bus.req_size;
    w_lane_n = bus.req_addr[1:0];
    w_err    = (bus.req_size == 2'b11)
            || ((bus.req_size == 2'b01) && bus.req_addr[0])
            || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
            || (|bus.req_addr[31:AW+2]);
  end
`else
  // Without trapping, high address bits simply wrap away.
  logic w_unused_hi;
  assign w_unused_hi = ^bus.req_addr[31:AW+2];

  always_comb begin
    w_err    = 1'b0;
    w_size_n = (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;
    w_lane_n = bus.req_addr[1:0];
    if (w_size_n == 2'b01) begin
      w_lane_n[0] = 1'b0;
    end else if (w_size_n == 2'b10) begin
      w_lane_n = 2'b00;
    end
  end
`endif

  // Store data is replicated across lanes so each byte lane just picks its own slice.
  always_comb begin
    w_be   = 4'b1111;
    w_wrep = bus.req_wdata;
    case (w_size_n)
      2'b00: begin
        w_be   = 4'b0001 << w_lane_n;
        w_wrep = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = w_lane_n[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        w_be   = 4'b1111;
        w_wrep = bus.req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_write      <= 1'b0;
      r_be         <= 4'b0000;
      r_wdata      <= 32'd0;
      r_idx        <= '0;
      r_shift      <= 2'b00;
      r_size       <= 2'b00;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_write <= bus.req_write;
            r_be    <= w_be;
            r_wdata <= w_wrep;
            r_idx   <= bus.req_addr[AW+1:2];
            r_shift <= w_lane_n;
            r_size  <= w_size_n;
            r_ready <= 1'b0;
            if (w_err) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_err        <= 1'b1;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= CNT_INIT;
              r_err   <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == 3'd0) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // One RAM per byte lane so each lane is a plain write-enable block RAM with a registered read.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH_WORDS];
      logic [7:0] r_rd;

      always_ff @(posedge clk) begin
        if (reset_n && w_do_access && r_write && r_be[gi]) begin
          r_mem[r_idx] <= r_wdata[gi*8 +: 8];
        end
      end

      // Cleared at accept so stores and trapped requests answer with zero data.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_rd <= 8'd0;
        end else if (w_accept) begin
          r_rd <= 8'd0;
        end else if (w_do_access && !r_write) begin
          r_rd <= r_mem[r_idx];
        end
      end

      assign w_raw[gi*8 +: 8] = r_rd;
    end
  endgenerate

  assign w_shifted = w_raw >> {r_shift, 3'b000};

  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    case (r_size)
      2'b00:   w_mask = 32'h0000_00FF;
      2'b01:   w_mask = 32'h0000_FFFF;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = w_shifted & w_mask;
  assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, reset-during-access sequence, then random
// traffic against a byte-addressed memory model.
module tb_mem_responder;
  localparam int DEPTH = 256;
  localparam int RL    = 2;
`ifdef MEM_ERR_TRAP_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mem_responder_if bus();

  mem_responder #(.DEPTH_WORDS(DEPTH), .READ_LAT(RL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] ref_mem [DEPTH*4];

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
    bit          hold;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Byte-addressed model: a request is a list of consecutive bytes starting at the effective address.
  function automatic void model(input logic wr, input logic [1:0] sz, input logic [31:0] ad,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int unsigned sz_e = sz;
    logic [31:0] a = ad;
    int unsigned base;
    rd = 32'd0;
    er = 1'b0;
    if (EN) begin
      if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
          || (a >> 2) >= DEPTH) begin
        er = 1'b1;
        return;
      end
    end else begin
      if (sz == 2'b11) sz_e = 2;
      if (sz_e == 1) a = a & ~32'd1;
      if (sz_e == 2) a = a & ~32'd3;
    end
    base = (((a >> 2) % DEPTH) * 4) + (a % 4);
    for (int i = 0; i < (1 << sz_e); i++) begin
      if (wr) ref_mem[base + i] = wd[8*i +: 8];
      else    rd[8*i +: 8] = ref_mem[base + i];
    end
  endfunction

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic [31:0] ad,
                        input logic [31:0] wd, input bit hold,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    check("idle_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_size  = sz;
    bus.req_addr  = ad;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
    lat = 0;
    rd  = 32'd0;
    er  = 1'b0;
    while (lat < 16) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) break;
      if (hold) check("busy_ready", 32'(bus.req_ready), 32'd0);
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
    $display("txn %s sz=%0d addr=%08h wd=%08h hold=%0b -> rd=%08h err=%0b lat=%0d",
             wr ? "ST" : "LD", sz, ad, wd, hold, rd, er, lat);
  endtask

  task automatic run_model(input logic wr, input logic [1:0] sz, input logic [31:0] ad,
                           input logic [31:0] wd, input bit hold);
    logic [31:0] exp_rd, got_rd;
    logic        exp_er, got_er;
    int          lat;
    model(wr, sz, ad, wd, exp_rd, exp_er);
    do_req(wr, sz, ad, wd, hold, got_rd, got_er, lat);
    check("rnd_rdata", got_rd, exp_rd);
    check("rnd_err", 32'(got_er), 32'(exp_er));
    check("rnd_latency", 32'(lat), exp_er ? 32'd1 : 32'(RL + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] a;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;

    tbl[0]  = '{1'b1, 2'd2, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 2'd2, 32'h10,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 32'h13,  32'h000000AA, 1'b0, 32'h0, 1'b0};
    tbl[3]  = '{1'b0, 2'd2, 32'h10,  32'h0,        1'b0, 32'hAAADBEEF, 1'b0};
    tbl[4]  = '{1'b0, 2'd1, 32'h12,  32'h0,        1'b0, 32'h0000AAAD, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 32'h11,  32'h0,        1'b0, 32'h000000BE, 1'b0};
    tbl[6]  = '{1'b0, 2'd2, 32'h12,  32'h0,        1'b0, EN ? 32'h0 : 32'hAAADBEEF, EN};
    tbl[7]  = '{1'b1, 2'd2, 32'h0,   32'h0BADF00D, 1'b0, 32'h0, 1'b0};
    tbl[8]  = '{1'b1, 2'd2, 32'h400, 32'h12345678, 1'b0, 32'h0, EN};
    tbl[9]  = '{1'b0, 2'd2, 32'h0,   32'h0,        1'b0, EN ? 32'h0BADF00D : 32'h12345678, 1'b0};
    tbl[10] = '{1'b0, 2'd3, 32'h10,  32'h0,        1'b0, EN ? 32'h0 : 32'hAAADBEEF, EN};
    tbl[11] = '{1'b0, 2'd1, 32'h11,  32'h0,        1'b1, EN ? 32'h0 : 32'h0000BEEF, EN};
    tbl[12] = '{1'b1, 2'd1, 32'h12,  32'h00005566, 1'b0, 32'h0, 1'b0};
    tbl[13] = '{1'b0, 2'd2, 32'h10,  32'h0,        1'b0, 32'h5566BEEF, 1'b0};

    // Reset for one edge, then idle outputs.
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);

    for (int i = 0; i < 14; i++) begin
      do_req(tbl[i].wr, tbl[i].sz, tbl[i].ad, tbl[i].wd, tbl[i].hold, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_er));
      check($sformatf("vec%0d_latency", i), 32'(lat), tbl[i].exp_er ? 32'd1 : 32'(RL + 1));
    end

    // Reset asserted at the access edge of a store: the store is abandoned.
    run_model(1'b1, 2'd2, 32'h20, 32'h11112222, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (RL) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_rdata", bus.resp_rdata, 32'd0);
    check("abort_err", 32'(bus.resp_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end
    $display("txn ST sz=2 addr=00000020 wd=cafef00d aborted by reset");
    do_req(1'b0, 2'd2, 32'h20, 32'h0, 1'b0, rd, er, lat);
    check("abort_prior_value", rd, 32'h11112222);

    // Fill every word so random loads always have a defined expectation.
    for (int w = 0; w < DEPTH; w++) begin
      run_model(1'b1, 2'd2, 32'(w * 4), $urandom, 1'b0);
    end

    for (int n = 0; n < 300; n++) begin
      a = 32'($urandom_range(0, DEPTH * 4 - 1));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 15)) << 20);
      run_model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom,
                1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
